// File: rtl/axis_sts_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axis_sts_rx                                                  |
// | Description : S2MM status-stream sink; parses 6-beat status frames into a  |
// |               flag/APP record with valid/ready and good/bad frame counters.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axis_sts_rx #(
    parameter int          C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
    parameter logic [3:0]  C_STS_TAG                     = 4'h5,
    parameter int          C_CNT_WIDTH                   = 16
) (
    input  logic                                       m_axi_s2mm_aclk,
    input  logic                                       rst,
    input  logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0]   s_axis_s2mm_sts_tdata,
    input  logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH/8-1:0] s_axis_s2mm_sts_tkeep,
    input  logic                                       s_axis_s2mm_sts_tvalid,
    input  logic                                       s_axis_s2mm_sts_tlast,
    output logic                                       s_axis_s2mm_sts_tready,
    output logic                                       rec_valid,
    input  logic                                       rec_ready,
    output logic [31:0]                                rec_flag,
    output logic [159:0]                               rec_app,
    output logic [C_CNT_WIDTH-1:0]                     frame_cnt,
    output logic [C_CNT_WIDTH-1:0]                     err_cnt,
    output logic                                       err_pulse,
    output logic [1:0]                                 err_code
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_app   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    localparam logic [2:0] c_first_idx = 3'd1;
    localparam logic [2:0] c_last_idx  = 3'd5;

    localparam logic [1:0] c_err_tag  = 2'd0;
    localparam logic [1:0] c_err_short = 2'd1;
    localparam logic [1:0] c_err_long  = 2'd2;
    localparam logic [1:0] c_err_keep  = 2'd3;

    localparam logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH/8-1:0] c_keep_all = '1;
    localparam logic [C_CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [C_CNT_WIDTH-1:0] c_cnt_one = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             r_state;
    logic [2:0]             r_idx;
    logic                   r_en;
    logic                   r_rec_valid;
    logic [31:0]            r_rec_flag;
    logic [31:0]            r_app [0:4];
    logic [C_CNT_WIDTH-1:0] r_frame_cnt;
    logic [C_CNT_WIDTH-1:0] r_err_cnt;
    logic                   r_err_pulse;
    logic [1:0]             r_err_code;

    logic       w_tready;
    logic       w_xfer;
    logic       w_keep_ok;
    logic       w_tag_ok;
    logic [1:0] w_state_nxt;
    logic [2:0] w_idx_nxt;
    logic       w_err;
    logic [1:0] w_err_code;
    logic       w_commit;
    logic       w_flag_we;
    logic       w_app_we;

    // IDLE readiness follows rec_ready directly so a record can be consumed and
    // the next flag beat accepted on the same edge; r_en holds tready low in reset.
    assign w_tready  = r_en & ((r_state != c_st_idle) | ~r_rec_valid | rec_ready);
    assign w_xfer    = s_axis_s2mm_sts_tvalid & w_tready;
    assign w_keep_ok = (s_axis_s2mm_sts_tkeep == c_keep_all);
    assign w_tag_ok  = (s_axis_s2mm_sts_tdata[31:28] == C_STS_TAG);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_err       = 1'b0;
        w_err_code  = c_err_tag;
        w_commit    = 1'b0;
        w_flag_we   = 1'b0;
        w_app_we    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_xfer) begin
                    if (!w_keep_ok) begin
                        w_err      = 1'b1;
                        w_err_code = c_err_keep;
                    end else if (!w_tag_ok) begin
                        w_err      = 1'b1;
                        w_err_code = c_err_tag;
                    end else if (s_axis_s2mm_sts_tlast) begin
                        w_err      = 1'b1;
                        w_err_code = c_err_short;
                    end else begin
                        w_flag_we   = 1'b1;
                        w_idx_nxt   = c_first_idx;
                        w_state_nxt = c_st_app;
                    end
                    if (w_err) begin
                        w_state_nxt = s_axis_s2mm_sts_tlast ? c_st_idle : c_st_drain;
                    end
                end
            end
            c_st_app: begin
                if (w_xfer) begin
                    if (!w_keep_ok) begin
                        w_err       = 1'b1;
                        w_err_code  = c_err_keep;
                        w_state_nxt = s_axis_s2mm_sts_tlast ? c_st_idle : c_st_drain;
                    end else begin
                        w_app_we = 1'b1;
                        if (s_axis_s2mm_sts_tlast && (r_idx == c_last_idx)) begin
                            w_commit    = 1'b1;
                            w_state_nxt = c_st_idle;
                        end else if (s_axis_s2mm_sts_tlast) begin
                            w_err       = 1'b1;
                            w_err_code  = c_err_short;
                            w_state_nxt = c_st_idle;
                        end else if (r_idx == c_last_idx) begin
                            w_err       = 1'b1;
                            w_err_code  = c_err_long;
                            w_state_nxt = c_st_drain;
                        end else begin
                            w_idx_nxt = r_idx + 3'd1;
                        end
                    end
                end
            end
            c_st_drain: begin
                if (w_xfer && s_axis_s2mm_sts_tlast) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge m_axi_s2mm_aclk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_idx       <= 3'd0;
            r_en        <= 1'b0;
            r_rec_valid <= 1'b0;
            r_rec_flag  <= 32'd0;
            for (int i = 0; i < 5; i++) begin
                r_app[i] <= 32'd0;
            end
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= 2'd0;
        end else begin
            r_en        <= 1'b1;
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_err_pulse <= w_err;

            if (w_flag_we) begin
                r_rec_flag <= s_axis_s2mm_sts_tdata[31:0];
            end

            // APP beats land straight in the record; no frame can be in flight
            // while a previous record is still waiting to be consumed.
            if (w_app_we) begin
                case (r_idx)
                    3'd1:    r_app[0] <= s_axis_s2mm_sts_tdata[31:0];
                    3'd2:    r_app[1] <= s_axis_s2mm_sts_tdata[31:0];
                    3'd3:    r_app[2] <= s_axis_s2mm_sts_tdata[31:0];
                    3'd4:    r_app[3] <= s_axis_s2mm_sts_tdata[31:0];
                    3'd5:    r_app[4] <= s_axis_s2mm_sts_tdata[31:0];
                    default: ;
                endcase
            end

            if (w_commit) begin
                r_rec_valid <= 1'b1;
                if (r_frame_cnt != c_cnt_max) begin
                    r_frame_cnt <= r_frame_cnt + c_cnt_one;
                end
            end else if (r_rec_valid && rec_ready) begin
                r_rec_valid <= 1'b0;
            end

            if (w_err) begin
                r_err_code <= w_err_code;
                if (r_err_cnt != c_cnt_max) begin
                    r_err_cnt <= r_err_cnt + c_cnt_one;
                end
            end
        end
    end

    assign s_axis_s2mm_sts_tready = w_tready;
    assign rec_valid              = r_rec_valid;
    assign rec_flag               = r_rec_flag;
    assign rec_app                = {r_app[4], r_app[3], r_app[2], r_app[1], r_app[0]};
    assign frame_cnt              = r_frame_cnt;
    assign err_cnt                = r_err_cnt;
    assign err_pulse              = r_err_pulse;
    assign err_code               = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_axis_sts_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axis_sts_rx                                               |
// | Description : Directed self-checking bench for axis_sts_rx.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_axis_sts_rx;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  tdata = 32'd0;
    logic [3:0]   tkeep = 4'h0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic         tready;
    logic         rec_valid;
    logic         rec_ready = 1'b0;
    logic [31:0]  rec_flag;
    logic [159:0] rec_app;
    logic [15:0]  frame_cnt;
    logic [15:0]  err_cnt;
    logic         err_pulse;
    logic [1:0]   err_code;

    int n_checks = 0;
    int n_errors = 0;

    axis_sts_rx #(
        .C_S_AXIS_S2MM_STS_TDATA_WIDTH (32),
        .C_STS_TAG                     (4'h5),
        .C_CNT_WIDTH                   (16)
    ) dut (
        .m_axi_s2mm_aclk        (clk),
        .rst                    (rst),
        .s_axis_s2mm_sts_tdata  (tdata),
        .s_axis_s2mm_sts_tkeep  (tkeep),
        .s_axis_s2mm_sts_tvalid (tvalid),
        .s_axis_s2mm_sts_tlast  (tlast),
        .s_axis_s2mm_sts_tready (tready),
        .rec_valid              (rec_valid),
        .rec_ready              (rec_ready),
        .rec_flag               (rec_flag),
        .rec_app                (rec_app),
        .frame_cnt              (frame_cnt),
        .err_cnt                (err_cnt),
        .err_pulse              (err_pulse),
        .err_code               (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One beat; returns at posedge+1 after the transfer edge.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        @(negedge clk);
        while (tready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("beat_accept", tready, 1'b1);
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] f, input logic [159:0] app);
        send(f, 4'hf, 1'b0);
        send(app[31:0],    4'hf, 1'b0);
        send(app[63:32],   4'hf, 1'b0);
        send(app[95:64],   4'hf, 1'b0);
        send(app[127:96],  4'hf, 1'b0);
        send(app[159:128], 4'hf, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [159:0] app_g;
        logic [159:0] app_a;
        logic [159:0] app_b;
        app_g = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        app_a = {32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1};
        app_b = {32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1};

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_tready",    tready,    1'b0);
        chk("rst_rec_valid", rec_valid, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 16'd0);
        chk("rst_err_cnt",   err_cnt,   16'd0);
        chk("rst_err_pulse", err_pulse, 1'b0);
        chk("rst_err_code",  err_code,  2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_tready", tready, 1'b1);

        // Good frame, consumer always ready
        rec_ready = 1'b1;
        send(32'h5000_0000, 4'hf, 1'b0);
        send(32'h11, 4'hf, 1'b0);
        send(32'h22, 4'hf, 1'b0);
        send(32'h33, 4'hf, 1'b0);
        send(32'h44, 4'hf, 1'b0);
        chk("good_not_yet_valid", rec_valid, 1'b0);
        send(32'h55, 4'hf, 1'b1);
        chk("good_rec_valid", rec_valid, 1'b1);
        chk("good_rec_flag",  rec_flag,  32'h5000_0000);
        chk("good_rec_app",   rec_app,   app_g);
        chk("good_frame_cnt", frame_cnt, 16'd1);
        chk("good_err_cnt",   err_cnt,   16'd0);
        chk("good_err_pulse", err_pulse, 1'b0);
        @(posedge clk);
        #1;
        chk("good_valid_one_cycle", rec_valid, 1'b0);

        // Backpressure: record held until consumed, then next frame accepted
        do_reset();
        rec_ready = 1'b0;
        send_frame(32'h5000_00A0, app_a);
        chk("bp_a_valid", rec_valid, 1'b1);
        tdata  = 32'h5000_00B0;
        tkeep  = 4'hf;
        tlast  = 1'b0;
        tvalid = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_tready_low",  tready,    1'b0);
        chk("bp_a_held",      rec_valid, 1'b1);
        chk("bp_a_app",       rec_app,   app_a);
        chk("bp_a_flag",      rec_flag,  32'h5000_00A0);
        rec_ready = 1'b1;
        #1;
        chk("bp_tready_consume", tready, 1'b1);
        @(posedge clk);
        #1;
        rec_ready = 1'b0;
        tvalid    = 1'b0;
        chk("bp_a_consumed", rec_valid, 1'b0);
        send(app_b[31:0],    4'hf, 1'b0);
        send(app_b[63:32],   4'hf, 1'b0);
        send(app_b[95:64],   4'hf, 1'b0);
        send(app_b[127:96],  4'hf, 1'b0);
        send(app_b[159:128], 4'hf, 1'b1);
        chk("bp_b_valid",     rec_valid, 1'b1);
        chk("bp_b_app",       rec_app,   app_b);
        chk("bp_b_flag",      rec_flag,  32'h5000_00B0);
        chk("bp_frame_cnt",   frame_cnt, 16'd2);
        rec_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_b_consumed", rec_valid, 1'b0);

        // Bad tag, then a good frame
        do_reset();
        send(32'h3000_0000, 4'hf, 1'b0);
        chk("tag_err_pulse", err_pulse, 1'b1);
        chk("tag_err_code",  err_code,  2'd0);
        chk("tag_err_cnt",   err_cnt,   16'd1);
        send(32'h1, 4'hf, 1'b0);
        send(32'h2, 4'hf, 1'b0);
        send(32'h3, 4'hf, 1'b0);
        send(32'h4, 4'hf, 1'b0);
        send(32'h5, 4'hf, 1'b1);
        chk("tag_pulse_once", err_pulse, 1'b0);
        chk("tag_err_cnt_hold", err_cnt, 16'd1);
        chk("tag_no_valid",  rec_valid, 1'b0);
        chk("tag_frame_cnt", frame_cnt, 16'd0);
        send_frame(32'h5000_0000, app_g);
        chk("tag_after_valid", rec_valid, 1'b1);
        chk("tag_after_app",   rec_app,   app_g);
        chk("tag_after_frame_cnt", frame_cnt, 16'd1);
        chk("tag_after_err_cnt",   err_cnt,   16'd1);

        // Short frame then long frame
        do_reset();
        send(32'h5000_0000, 4'hf, 1'b0);
        send(32'h1, 4'hf, 1'b0);
        send(32'h2, 4'hf, 1'b0);
        send(32'h3, 4'hf, 1'b1);
        chk("short_err_pulse", err_pulse, 1'b1);
        chk("short_err_code",  err_code,  2'd1);
        chk("short_err_cnt",   err_cnt,   16'd1);
        send(32'h5000_0000, 4'hf, 1'b0);
        send(32'h1, 4'hf, 1'b0);
        send(32'h2, 4'hf, 1'b0);
        send(32'h3, 4'hf, 1'b0);
        send(32'h4, 4'hf, 1'b0);
        send(32'h5, 4'hf, 1'b0);
        chk("long_err_pulse", err_pulse, 1'b1);
        chk("long_err_code",  err_code,  2'd2);
        chk("long_err_cnt",   err_cnt,   16'd2);
        chk("long_no_valid",  rec_valid, 1'b0);
        chk("long_drain_tready", tready, 1'b1);
        send(32'h6, 4'hf, 1'b0);
        chk("long_drain_no_pulse", err_pulse, 1'b0);
        send(32'h7, 4'hf, 1'b1);
        chk("long_err_cnt_final", err_cnt,   16'd2);
        chk("long_code_hold",     err_code,  2'd2);
        chk("long_frame_cnt",     frame_cnt, 16'd0);

        // tkeep error on beat 2
        do_reset();
        send(32'h5000_0000, 4'hf, 1'b0);
        send(32'h1, 4'hf, 1'b0);
        send(32'h2, 4'h7, 1'b0);
        chk("keep_err_pulse", err_pulse, 1'b1);
        chk("keep_err_code",  err_code,  2'd3);
        chk("keep_err_cnt",   err_cnt,   16'd1);
        send(32'h3, 4'hf, 1'b0);
        send(32'h4, 4'hf, 1'b0);
        send(32'h5, 4'hf, 1'b1);
        chk("keep_err_cnt_final", err_cnt,   16'd1);
        chk("keep_no_valid",      rec_valid, 1'b0);
        send_frame(32'h5000_0000, app_g);
        chk("keep_after_valid",     rec_valid, 1'b1);
        chk("keep_after_frame_cnt", frame_cnt, 16'd1);

        // Reset in the middle of a frame
        send(32'h5000_0000, 4'hf, 1'b0);
        send(32'h1, 4'hf, 1'b0);
        send(32'h2, 4'hf, 1'b0);
        send(32'h3, 4'hf, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_tready",    tready,    1'b0);
        chk("mid_rst_rec_valid", rec_valid, 1'b0);
        chk("mid_rst_rec_flag",  rec_flag,  32'd0);
        chk("mid_rst_rec_app",   rec_app,   160'd0);
        chk("mid_rst_frame_cnt", frame_cnt, 16'd0);
        chk("mid_rst_err_cnt",   err_cnt,   16'd0);
        chk("mid_rst_err_code",  err_code,  2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(32'h5000_0000, app_g);
        chk("post_rst_valid",     rec_valid, 1'b1);
        chk("post_rst_app",       rec_app,   app_g);
        chk("post_rst_frame_cnt", frame_cnt, 16'd1);
        chk("post_rst_err_cnt",   err_cnt,   16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
